// File: rtl/song_recorder.sv
// song_recorder: records key presses as {duration, note_pitch} entries into a
// 128-word song memory. Address 0 receives the note count when the recording
// closes; notes fill addresses 1..127. Durations are measured in ticks of
// TICK_DIV clock cycles and saturate at 65535.
// Optional build macro REC_REST_EN: silences between notes are timed and
// written as entries with note_pitch 0.
module song_recorder #(
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  key_in,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [6:0]  wr_addr,
    output logic [25:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic [6:0]  note_count
);

`ifdef REC_REST_EN
    localparam bit REST_EN = 1'b1;
`else
    localparam bit REST_EN = 1'b0;
`endif

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state;
    logic [9:0]    key_q;
    logic [9:0]    key_prev;
    logic [9:0]    cur_note;
    logic [PW-1:0] presc;
    logic [15:0]   dur;
    logic [6:0]    addr;       // next note address to be written
    logic          stop_pend;  // stop seen while a note write is outstanding

    logic          tick;
    logic          key_change;
    logic [15:0]   dur_next;
    logic [15:0]   dur_entry;

    assign key_change = (key_q != key_prev);
    assign tick       = (state != S_IDLE) && (presc == PW'(TICK_DIV - 1));
    assign dur_next   = (tick && dur != 16'hFFFF) ? dur + 16'd1 : dur;
    // A note released before the first tick still occupies one tick
    assign dur_entry  = (dur == 16'd0) ? 16'd1 : dur;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // Register the key bus and keep one cycle of history for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= '0;
            key_prev <= '0;
        end else begin
            key_q    <= key_in;
            key_prev <= key_q;
        end
    end

    // Recording FSM with prescaler, duration timer and write handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            dur        <= '0;
            cur_note   <= '0;
            addr       <= '0;
            stop_pend  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            full       <= 1'b0;
            note_count <= '0;
        end else begin
            // Free-running prescaler outside IDLE; HOLD entry overrides below
            if (state == S_IDLE || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_WAIT;
                        addr       <= 7'd1;
                        note_count <= '0;
                        full       <= 1'b0;
                        stop_pend  <= 1'b0;
                        dur        <= '0;
                    end
                end

                S_WAIT: begin
                    if (REST_EN)
                        dur <= dur_next;
                    if (stop) begin
                        state <= S_FINISH;
                    end else if (key_q != '0) begin
                        // A rest is only meaningful once a note precedes it
                        if (REST_EN && addr != 7'd1) begin
                            state   <= S_WRITE;
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= {dur_entry, 10'd0};
                        end else begin
                            state    <= S_HOLD;
                            cur_note <= key_q;
                            dur      <= '0;
                            presc    <= '0;
                        end
                    end
                end

                S_HOLD: begin
                    dur <= dur_next;
                    if (key_change || stop) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= {dur_entry, cur_note};
                        if (stop)
                            stop_pend <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (wr_ready) begin
                        wr_en      <= 1'b0;
                        addr       <= addr + 7'd1;
                        note_count <= note_count + 7'd1;
                        if (addr == 7'd127)
                            full <= 1'b1;
                        // Key activity during the write is not queued; decide
                        // from whatever key_q holds now
                        if (addr == 7'd127 || stop || stop_pend) begin
                            state <= S_FINISH;
                        end else if (key_q != '0) begin
                            state    <= S_HOLD;
                            cur_note <= key_q;
                            dur      <= '0;
                            presc    <= '0;
                        end else begin
                            state <= S_WAIT;
                            dur   <= '0;
                        end
                    end
                end

                S_FINISH: begin
                    // First cycle keeps wr_en low after a preceding note write
                    if (!wr_en) begin
                        wr_en   <= 1'b1;
                        wr_addr <= 7'd0;
                        wr_data <= {19'd0, note_count};
                    end else if (wr_ready) begin
                        wr_en <= 1'b0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: randomized and directed stimulus for song_recorder with
// TICK_DIV = 4. Expected song entries are built from the played key segments
// (note, length in cycles) and compared with the observed memory writes;
// a per-cycle monitor checks handshake stability, note_count, full and done.
module tb_song_recorder;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  key_in = '0;
    logic        wr_ready = 1'b1;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [25:0] wr_data;
    logic        busy;
    logic        done;
    logic        full;
    logic [6:0]  note_count;

    song_recorder #(.TICK_DIV(TICK)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .key_in(key_in),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .full(full), .note_count(note_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] note; int lo; int hi; } exp_t;

    int          total = 0;
    int          bad = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random bounded stalls, 2: never ready
    int          done_cnt = 0;
    logic [32:0] obs_q[$];       // accepted writes {addr, data}
    exp_t        expq[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // Entry held for len cycles of key_in: about len/TICK ticks, at least 1
    function automatic void add_ent(input logic [9:0] n, input int len);
        exp_t e;
        e.note = n;
        e.hi   = len / TICK + 1;
        e.lo   = (len - 8) / TICK;
        if (e.lo < 1) e.lo = 1;
        expq.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [9:0] k, input int len);
        key_in = k;
        repeat (len) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) step();
        chk("done_seen", 64'(done_cnt > d0), 64'd1);
    endtask

    task automatic cmp_rec();
        chk("n_writes", 64'(obs_q.size()), 64'(expq.size() + 1));
        for (int j = 0; j < expq.size() && j < obs_q.size(); j++) begin
            chk("entry_addr", 64'(obs_q[j][32:26]), 64'(j + 1));
            chk("entry_note", 64'(obs_q[j][9:0]), 64'(expq[j].note));
            chk_rng("entry_dur", int'(obs_q[j][25:10]), expq[j].lo, expq[j].hi);
        end
        if (obs_q.size() > expq.size()) begin
            chk("count_addr", 64'(obs_q[expq.size()][32:26]), 64'd0);
            chk("count_data", 64'(obs_q[expq.size()][25:0]), 64'(expq.size()));
        end
        chk("note_count", 64'(note_count), 64'(expq.size()));
        chk("busy_after", 64'(busy), 64'd0);
        obs_q.delete();
        expq.delete();
    endtask

    // Memory-side ready generator; random mode never stalls more than 3 cycles
    initial begin
        int zrun;
        zrun = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                wr_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                if (zrun >= 3 || $urandom_range(0, 3) != 0) begin
                    wr_ready = 1'b1;
                    zrun = 0;
                end else begin
                    wr_ready = 1'b0;
                    zrun++;
                end
            end else begin
                wr_ready = 1'b0;
            end
        end
    end

    // Per-cycle monitor: handshake rules, note_count/full model, done pulse
    initial begin
        logic        pend_q, acc_q, done_q, last_a0, full_m;
        logic [6:0]  pend_addr;
        logic [25:0] pend_data;
        int          cnt_m;
        pend_q = 0; acc_q = 0; done_q = 0; last_a0 = 0; full_m = 0; cnt_m = 0;
        pend_addr = '0; pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", 64'({wr_en, wr_addr, wr_data, busy, done, full, note_count}), 64'd0);
                pend_q = 0; acc_q = 0; done_q = 0; last_a0 = 0; full_m = 0; cnt_m = 0;
            end else begin
                if (pend_q)
                    chk("wr_hold", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, pend_addr, pend_data}));
                if (acc_q)
                    chk("wr_drop", 64'(wr_en), 64'd0);
                chk("count_live", 64'(note_count), 64'(cnt_m));
                chk("full_live", 64'(full), 64'(full_m));
                if (done_q)
                    chk("done_then_idle", 64'({done, busy}), 64'd0);
                if (done) begin
                    chk("done_after_count", 64'(last_a0), 64'd1);
                    done_cnt++;
                end
                pend_q    = wr_en && !wr_ready;
                pend_addr = wr_addr;
                pend_data = wr_data;
                acc_q     = wr_en && wr_ready;
                if (acc_q) begin
                    obs_q.push_back({wr_addr, wr_data});
                    if (wr_addr != 7'd0) cnt_m++;
                    if (wr_addr == 7'd127) full_m = 1;
                    last_a0 = (wr_addr == 7'd0);
                end
                if (start && !busy) begin
                    cnt_m = 0;
                    full_m = 0;
                end
                done_q = done;
            end
        end
    end

    initial begin
        #3ms;
        bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic rand_rec();
        int          n, len, g, d0;
        logic [9:0]  k, prev;
        rdy_mode = 1;
        prev = '0;
        n = int'($urandom_range(1, 10));
        d0 = done_cnt;
        pulse_start();
        play(10'h000, int'($urandom_range(0, 10)));
        for (int i = 0; i < n; i++) begin
            len = int'($urandom_range(12, 40));
            if (i > 0 && $urandom_range(0, 1) == 1) begin
                g = int'($urandom_range(12, 30));
                play(10'h000, g);
`ifdef REC_REST_EN
                add_ent(10'h000, g);
`endif
                prev = '0;
            end
            k = 10'($urandom_range(1, 1023));
            while (k == prev) k = 10'($urandom_range(1, 1023));
            if (i == n - 1 && $urandom_range(0, 1) == 1) begin
                // stop while the last key is still held commits it
                play(k, len);
                pulse_stop();
                add_ent(k, len);
                play(k, 3);
                play(10'h000, 4);
            end else begin
                play(k, len);
                add_ent(k, len);
                prev = k;
                if (i == n - 1) begin
                    play(10'h000, 6);
                    pulse_stop();
                end
            end
        end
        wait_done(d0);
        cmp_rec();
        play(10'h000, 3);
    endtask

    initial begin
        int d0;
        repeat (3) step();
        chk("reset_state", 64'({wr_en, wr_addr, wr_data, busy, done, full, note_count}), 64'd0);
        rst = 1'b0;
        step();

        // single note, released, then stop
        rdy_mode = 0;
        d0 = done_cnt;
        pulse_start();
        chk("busy_start", 64'(busy), 64'd1);
        play(10'h041, 20);
        play(10'h000, 4);
        pulse_stop();
        add_ent(10'h041, 20);
        wait_done(d0);
        chk("t1_nwr", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() >= 2) begin
            chk_rng("t1_dur", int'(obs_q[0][25:10]), 4, 6);
            chk("t1_note", 64'(obs_q[0][9:0]), 64'h041);
            chk("t1_count", 64'(obs_q[1]), 64'({7'd0, 26'd1}));
        end
        cmp_rec();

        // back-to-back keys with no gap: two adjacent entries, no rest
        d0 = done_cnt;
        pulse_start();
        play(10'h041, 20);
        play(10'h082, 20);
        play(10'h000, 4);
        pulse_stop();
        add_ent(10'h041, 20);
        add_ent(10'h082, 20);
        wait_done(d0);
        if (obs_q.size() >= 2)
            chk("t2_second", 64'({obs_q[1][32:26], obs_q[1][9:0]}), 64'({7'd2, 10'h082}));
        cmp_rec();

        // memory stalls; stop arrives while the write is pending
        d0 = done_cnt;
        pulse_start();
        rdy_mode = 2;
        play(10'h041, 20);
        play(10'h000, 14);
        chk("t3_pending", 64'({wr_en, wr_addr}), 64'({1'b1, 7'd1}));
        chk("t3_nowrite", 64'(obs_q.size()), 64'd0);
        pulse_stop();
        rdy_mode = 0;
        add_ent(10'h041, 20);
        wait_done(d0);
        cmp_rec();

        // start and stop together in IDLE: start wins; empty recording
        d0 = done_cnt;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("t4_started", 64'(busy), 64'd1);
        play(10'h000, 5);
        pulse_stop();
        wait_done(d0);
        if (obs_q.size() >= 1)
            chk("t4_empty", 64'(obs_q[0]), 64'd0);
        cmp_rec();

        // note, silence, note; a start while recording is ignored
        d0 = done_cnt;
        pulse_start();
        play(10'h041, 10);
        pulse_start();
        play(10'h041, 9);
        play(10'h000, 12);
        play(10'h082, 20);
        play(10'h000, 4);
        pulse_stop();
        add_ent(10'h041, 20);
`ifdef REC_REST_EN
        add_ent(10'h000, 12);
`endif
        add_ent(10'h082, 20);
        wait_done(d0);
`ifdef REC_REST_EN
        chk("t5_nwr", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() >= 4) begin
            chk_rng("t5_rest_dur", int'(obs_q[1][25:10]), 2, 4);
            chk("t5_rest_note", 64'(obs_q[1][9:0]), 64'd0);
            chk("t5_count", 64'(obs_q[3][25:0]), 64'd3);
        end
`else
        chk("t5_nwr", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() >= 3)
            chk("t5_count", 64'(obs_q[2][25:0]), 64'd2);
`endif
        cmp_rec();

        // asynchronous reset while holding a note abandons the recording
        pulse_start();
        play(10'h041, 15);
        play(10'h082, 15);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_now", 64'({wr_en, wr_addr, wr_data, busy, done, full, note_count}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        play(10'h000, 20);
        chk("t6_idle", 64'(busy), 64'd0);
        d0 = 0;
        foreach (obs_q[j]) if (obs_q[j][32:26] == 7'd0) d0++;
        chk("t6_no_count_wr", 64'(d0), 64'd0);
        obs_q.delete();
        d0 = done_cnt;
        pulse_start();
        play(10'h082, 16);
        play(10'h000, 4);
        pulse_stop();
        add_ent(10'h082, 16);
        wait_done(d0);
        cmp_rec();

        // fill all 127 note slots with short alternating keys
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 140 && done_cnt == d0; i++) begin
            play((i % 2) ? 10'h082 : 10'h041, 8);
            if (i < 127) add_ent((i % 2) ? 10'h082 : 10'h041, 8);
        end
        wait_done(d0);
        chk("t7_full", 64'(full), 64'd1);
        if (obs_q.size() >= 128)
            chk("t7_count", 64'(obs_q[127]), 64'({7'd0, 26'd127}));
        cmp_rec();
        for (int i = 0; i < 6; i++) play((i % 2) ? 10'h041 : 10'h082, 6);
        chk("t7_ignored", 64'(obs_q.size()), 64'd0);
        chk("t7_full_kept", 64'({full, busy}), 64'({1'b1, 1'b0}));
        key_in = '0;
        d0 = done_cnt;
        pulse_start();
        chk("t7_full_clr", 64'(full), 64'd0);
        play(10'h000, 3);
        pulse_stop();
        wait_done(d0);
        cmp_rec();

        for (int r = 0; r < 8; r++) rand_rec();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
